mux4_rr_arbiter: RTL
====================

Name: mux4_rr_arbiter

Overview:
Shares one 4-bit output channel among four 4-bit requesters. It runs a round-robin arbiter and drives the select of a 4-to-1, 4-bit data mux into a registered valid/ready output stage. A grant is held for a burst of beats, so a requester's consecutive data stays contiguous on the channel. It sits between the per-source producers and the shared downstream consumer.

Parameters:
MAX_BURST, 4, maximum beats per grant when the burst limit is compiled in; legal range 1..15.
CNT_W, 4, width of the internal beat counter; must satisfy 2^CNT_W > MAX_BURST.

Ports:
clk  in  1  single clock; all state changes on the rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
req  in  4  per-requester request; bit i means data_i holds a valid beat.
data_a  in  4  requester 0 data.
data_b  in  4  requester 1 data.
data_c  in  4  requester 2 data.
data_d  in  4  requester 3 data.
gnt  out  4  one-hot registered grant; all zero when idle.
ack  out  4  combinational per-requester beat-accept strobe.
out_data  out  4  registered channel data.
out_src  out  2  registered index of the source of out_data; equals the mux select at capture time.
out_valid  out  1  out_data holds a beat.
out_ready  in  1  consumer accepts a beat when out_valid and out_ready are both high.

Behaviour:
- Interface (decided): one clock; reset asynchronous and active-low, on ports clk and rst_n.
- Reset values:
  - gnt=0, out_valid=0, out_data=0, out_src=0.
  - State IDLE, rr_ptr=3 (so requester 0 wins first), beat_cnt=0.
- sel = encode(gnt) drives the 4:1 mux: 00=data_a, 01=data_b, 10=data_c, 11=data_d.
- space = !out_valid | out_ready.
- ack[i] = gnt[i] & req[i] & space, in GRANT state only.
- State IDLE:
  - If req != 0, pick the first set bit searching rr_ptr+1, rr_ptr+2, ... (mod 4).
  - Register gnt for the winner, clear beat_cnt, go to GRANT.
  - gnt becomes visible the next cycle. No ack is issued in IDLE.
- State GRANT, with g = granted index:
  - Accept (ack[g]=1): out_data<=mux output, out_src<=g, out_valid<=1, beat_cnt++.
  - Release when either condition holds:
    - req[g]=0 in a cycle with no accept; or
    - an accept with beat_cnt==MAX_BURST-1 (burst limit only).
  - On release: gnt<=0, rr_ptr<=g, go to IDLE.
  - There is always exactly one grant-free cycle between grants.
- Output stage:
  - If out_valid & out_ready and there is no accept in the same cycle, out_valid<=0.
  - Accept and drain in the same cycle: new beat replaces old, out_valid stays 1 (full throughput).
- Latency: req rises in IDLE at cycle N -> gnt at N+1 -> ack at N+1 if space -> out_valid at N+2.
- Boundary conditions:
  - req[g] dropping while the output is stalled is not a release until a cycle with no accept and req[g]=0. Data is never lost: a beat is consumed only on ack.
  - Requests from non-granted sources are ignored until the next IDLE.
  - All four requesting continuously: grant order is 0,1,2,3,0...
  - rst_n asserted mid-burst: all outputs clear immediately (asynchronous). A pending out_data beat is discarded.
  - beat_cnt saturates at MAX_BURST-1 and never wraps.

Optional Feature:
Macro MUX4_ARB_BURST_LIMIT_EN.
- Defined: the grant is released after MAX_BURST accepted beats even if req[g] stays high, and the others are then arbitrated fairly.
- Undefined: the grant is held until req[g] drops. beat_cnt is not compared, and MAX_BURST has no effect on behaviour.

Test Plan:
1. Reset: rst_n=0 with random inputs -> gnt=0, out_valid=0, out_data=0, out_src=0; release reset, req=0 -> stays idle.
2. Single source: req=0010, data_b=4'hA, out_ready=1 -> gnt=0010 one cycle later, out_data=A, out_src=1, out_valid two cycles after req.
3. Round-robin: req=1111 held, limit defined, MAX_BURST=2, out_ready=1 -> two beats each from src 0,1,2,3,0, with one gnt=0 cycle between bursts.
4. Backpressure: single grant on src 2, out_ready=0 for 3 cycles -> ack[2]=0 during the stall, out_data unchanged, no beat lost; on out_ready=1, one beat per cycle resumes.
5. Release by drop: src 3 sends 3 beats then req[3]=0 while req[0]=1 -> gnt goes 1000 -> 0000 -> 0001; rr_ptr=3 so src 0 wins.
6. Async reset mid-burst: gnt=0100, out_valid=1, rst_n pulsed low between edges -> all outputs zero immediately; after release, first grant goes to src 0.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin burst arbiter steering a 4:1 data mux into a registered valid/ready stage.
// Define MUX4_ARB_BURST_LIMIT_EN to force a release after MAX_BURST accepted beats.
module mux4_rr_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] data_a,
    input  logic [3:0] data_b,
    input  logic [3:0] data_c,
    input  logic [3:0] data_d,
    output logic [3:0] gnt,
    output logic [3:0] ack,
    output logic [3:0] out_data,
    output logic [1:0] out_src,
    output logic       out_valid,
    input  logic       out_ready
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_BURST - 1);

    state_t           state, state_nxt;
    logic [3:0]       gnt_nxt, mux_data;
    logic [1:0]       rr_ptr, rr_nxt, sel, win;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             space, accept, at_last, rel;

    assign sel      = {gnt[3] | gnt[2], gnt[3] | gnt[1]};
    assign space    = !out_valid || out_ready;
    assign ack      = (state == GRANT) ? (gnt & req & {4{space}}) : 4'b0;
    assign accept   = |ack;
    assign at_last  = (cnt == LAST);
    assign mux_data = sel[1] ? (sel[0] ? data_d : data_c) : (sel[0] ? data_b : data_a);

    // Scan from farthest to nearest so the requester just after rr_ptr wins.
    always_comb begin
        win = rr_ptr;
        for (int k = 4; k >= 1; k--)
            if (req[rr_ptr + 2'(k)]) win = rr_ptr + 2'(k);
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        rr_nxt    = rr_ptr;
        cnt_nxt   = cnt;
`ifdef MUX4_ARB_BURST_LIMIT_EN
        rel = (!accept && !req[sel]) || (accept && at_last);
`else
        rel = !accept && !req[sel];
`endif
        if (state == IDLE) begin
            if (|req) begin
                gnt_nxt   = 4'b0001 << win;
                cnt_nxt   = '0;
                state_nxt = GRANT;
            end
        end else begin
            if (accept && !at_last) cnt_nxt = cnt + 1'b1;
            if (rel) begin
                gnt_nxt   = 4'b0;
                rr_nxt    = sel;
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= 4'b0;
            rr_ptr    <= 2'd3;
            cnt       <= '0;
            out_data  <= 4'b0;
            out_src   <= 2'd0;
            out_valid <= 1'b0;
        end else begin
            state  <= state_nxt;
            gnt    <= gnt_nxt;
            rr_ptr <= rr_nxt;
            cnt    <= cnt_nxt;
            // A same-cycle accept overwrites the draining beat, keeping full throughput.
            if (accept) begin
                out_data  <= mux_data;
                out_src   <= sel;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
